// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use bubble, waitrequest freeze, branch flush, watchdog.
// Optional performance counters (StallCnt/FlushCnt) enabled by `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 255,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] Rs1_ID,
  input  logic [REG_ADDR_W-1:0] Rs2_ID,
  input  logic                  UsesRs1_ID,
  input  logic                  UsesRs2_ID,
  input  logic [REG_ADDR_W-1:0] RdEx,
  input  logic                  MemRead_EX,
  input  logic                  BranchTaken_EX,
  input  logic                  MemAccess_MEM,
  input  logic                  avm_waitrequest,
  output logic                  Stall_IF,
  output logic                  Stall_ID,
  output logic                  Stall_EX,
  output logic                  Stall_MEM,
  output logic                  Bubble_EX,
  output logic                  Flush_IF,
  output logic                  Flush_ID,
  output logic                  Timeout,
  output logic [1:0]            State
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      StallCnt,
  output logic [CNT_W-1:0]      FlushCnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    LOAD_BUB = 2'd2,
    ERROR    = 2'd3
  } state_e;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                frz, lu;
  logic                stall_fe, stall_be, bubble, flush;

  always_comb begin
    frz = MemAccess_MEM && avm_waitrequest;
    lu  = MemRead_EX && (RdEx != '0) &&
          ((UsesRs1_ID && (Rs1_ID == RdEx)) || (UsesRs2_ID && (Rs2_ID == RdEx)));

    stall_fe   = 1'b0;
    stall_be   = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    state_d    = state_q;
    wait_cnt_d = '0;

    // RUN, MEM_WAIT and LOAD_BUB share one rule set; only ERROR differs.
    if (state_q == ERROR) begin
      stall_fe = 1'b1;
      stall_be = 1'b1;
    end else if (frz) begin
      stall_fe   = 1'b1;
      stall_be   = 1'b1;
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      state_d    = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? ERROR : MEM_WAIT;
    end else if (BranchTaken_EX) begin
      flush   = 1'b1;
      state_d = RUN;
    end else if (lu) begin
      stall_fe = 1'b1;
      bubble   = 1'b1;
      state_d  = LOAD_BUB;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs are masked by reset_n so that they read 0 while reset is held.
  always_comb begin
    Stall_IF  = reset_n && stall_fe;
    Stall_ID  = reset_n && stall_fe;
    Stall_EX  = reset_n && stall_be;
    Stall_MEM = reset_n && stall_be;
    Bubble_EX = reset_n && bubble;
    Flush_IF  = reset_n && flush;
    Flush_ID  = reset_n && flush;
    Timeout   = reset_n && (state_q == ERROR);
    State     = reset_n ? state_q : 2'd0;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall_IF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (Flush_IF && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences, random vs. model.
module tb_hazard_ctrl;
  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] Rs1_ID, Rs2_ID, RdEx;
  logic       UsesRs1_ID, UsesRs2_ID, MemRead_EX, BranchTaken_EX, MemAccess_MEM, avm_waitrequest;
  logic       Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Bubble_EX, Flush_IF, Flush_ID, Timeout;
  logic [1:0] State;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  hazard_ctrl #(.REG_ADDR_W(5), .MAX_WAIT(MW), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .UsesRs1_ID(UsesRs1_ID), .UsesRs2_ID(UsesRs2_ID),
    .RdEx(RdEx), .MemRead_EX(MemRead_EX), .BranchTaken_EX(BranchTaken_EX),
    .MemAccess_MEM(MemAccess_MEM), .avm_waitrequest(avm_waitrequest),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Stall_EX(Stall_EX), .Stall_MEM(Stall_MEM),
    .Bubble_EX(Bubble_EX), .Flush_IF(Flush_IF), .Flush_ID(Flush_ID),
    .Timeout(Timeout), .State(State)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, ma, wr;
  } in_t;

  typedef struct {
    string      name;
    in_t        v;
    logic [6:0] exp;   // {Stall_IF,Stall_ID,Stall_EX,Stall_MEM,Bubble_EX,Flush_IF,Flush_ID}
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: sticky error flag, length of the current freeze run, last-cycle events.
  bit          m_err;
  int          m_run;
  bit          m_prev_frz, m_prev_bub;
  int unsigned m_sc, m_fc;
  in_t         cur;

  function automatic in_t mk(int rs1, int rs2, int u1, int u2, int rd,
                             int mr, int br, int ma, int wr);
    in_t r;
    r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = 1'(u1); r.u2 = 1'(u2);
    r.rd  = 5'(rd);  r.mr  = 1'(mr);  r.br = 1'(br); r.ma = 1'(ma); r.wr = 1'(wr);
    return r;
  endfunction

  function automatic logic [6:0] outs();
    return {Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Bubble_EX, Flush_IF, Flush_ID};
  endfunction

  function automatic logic [6:0] m_outs(in_t v);
    bit frz, lu, hold_fe, bub, fl;
    frz = v.ma && v.wr;
    lu  = v.mr && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (m_err) return 7'b1111000;
    fl      = !frz && v.br;
    bub     = !frz && !v.br && lu;
    hold_fe = frz || bub;
    return {hold_fe, hold_fe, frz, frz, bub, fl, fl};
  endfunction

  function automatic logic [1:0] m_state();
    if (m_err)      return 2'd3;
    if (m_prev_frz) return 2'd1;
    if (m_prev_bub) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(in_t v);
    cur = v;
    Rs1_ID = v.rs1; Rs2_ID = v.rs2; UsesRs1_ID = v.u1; UsesRs2_ID = v.u2;
    RdEx = v.rd; MemRead_EX = v.mr; BranchTaken_EX = v.br;
    MemAccess_MEM = v.ma; avm_waitrequest = v.wr;
  endtask

  // Drive at posedge+1, compare against the model near the falling edge.
  task automatic apply(in_t v, string tag);
    set_in(v);
    #4;
    chk({tag, " outs"}, 32'(outs()), 32'(m_outs(v)));
    chk({tag, " state"}, 32'(State), 32'(m_state()));
    chk({tag, " timeout"}, 32'(Timeout), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, " stallcnt"}, StallCnt, m_sc);
    chk({tag, " flushcnt"}, FlushCnt, m_fc);
`endif
  endtask

  task automatic tick();
    logic [6:0] e;
    bit frz;
    @(posedge clk);
    e   = m_outs(cur);
    frz = cur.ma && cur.wr;
    if (e[6] && m_sc != 32'hFFFF_FFFF) m_sc++;
    if (e[1] && m_fc != 32'hFFFF_FFFF) m_fc++;
    if (!m_err) begin
      m_run      = frz ? m_run + 1 : 0;
      m_prev_frz = frz;
      m_prev_bub = e[2];
      if (m_run > MW) m_err = 1;
    end
    #1;
  endtask

  task automatic step(in_t v, string tag);
    apply(v, tag);
    tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    set_in(mk(3, 3, 1, 1, 3, 1, 1, 1, 1));
    #2;
    chk("reset outs", 32'({outs(), Timeout, State}), 32'd0);
    @(posedge clk);
    #1;
    chk("reset held outs", 32'({outs(), Timeout, State}), 32'd0);
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    m_err = 0; m_run = 0; m_prev_frz = 0; m_prev_bub = 0; m_sc = 0; m_fc = 0;
  endtask

  vec_t tbl[12];
  in_t  idle, frzv, brfz;

  initial begin
    reset_n = 1'b0;
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    frzv = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    brfz = mk(0, 0, 0, 0, 0, 0, 1, 1, 1);

    tbl[0]  = '{"idle",          idle,                          7'b0000000};
    tbl[1]  = '{"lu rs1",        mk(3, 0, 1, 0, 3, 1, 0, 0, 0), 7'b1100100};
    tbl[2]  = '{"rs1 unused",    mk(3, 0, 0, 0, 3, 1, 0, 0, 0), 7'b0000000};
    tbl[3]  = '{"load x0",       mk(0, 0, 1, 0, 0, 1, 0, 0, 0), 7'b0000000};
    tbl[4]  = '{"no load",       mk(3, 3, 1, 1, 3, 0, 0, 0, 0), 7'b0000000};
    tbl[5]  = '{"lu rs2",        mk(1, 5, 1, 1, 5, 1, 0, 0, 0), 7'b1100100};
    tbl[6]  = '{"branch",        mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 7'b0000011};
    tbl[7]  = '{"branch+lu",     mk(5, 0, 1, 0, 5, 1, 1, 0, 0), 7'b0000011};
    tbl[8]  = '{"freeze",        frzv,                          7'b1111000};
    tbl[9]  = '{"wr no access",  mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 7'b0000000};
    tbl[10] = '{"frz+br+lu",     mk(2, 0, 1, 0, 2, 1, 1, 1, 1), 7'b1111000};
    tbl[11] = '{"access no wr",  mk(2, 0, 1, 0, 2, 1, 0, 1, 0), 7'b1100100};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].v, tbl[i].name);
      chk({"tbl ", tbl[i].name}, 32'(outs()), 32'(tbl[i].exp));
      tick();
    end

    // Load-use on Rs2: one bubble, LOAD_BUB visible next cycle, then back to RUN.
    do_reset();
    apply(mk(0, 5, 0, 1, 5, 1, 0, 0, 0), "lu2");
    chk("lu2 stall/bubble", 32'({Stall_IF, Stall_ID, Bubble_EX}), 32'd7);
    tick();
    apply(idle, "lu2 after");
    chk("lu2 after outs", 32'(outs()), 32'd0);
    chk("lu2 state bub", 32'(State), 32'd2);
    tick();
    apply(idle, "lu2 after2");
    chk("lu2 state run", 32'(State), 32'd0);
    tick();

    // waitrequest for exactly MAX_WAIT cycles: no error.
    for (int i = 0; i < MW; i++) begin
      apply(frzv, "wait4");
      chk("wait4 stalls", 32'({Stall_IF, Stall_ID, Stall_EX, Stall_MEM}), 32'hF);
      tick();
    end
    apply(idle, "wait4 rel");
    chk("wait4 released", 32'({Stall_IF, Stall_EX, Timeout}), 32'd0);
    chk("wait4 state", 32'(State), 32'd1);
    tick();

    // MAX_WAIT+1 cycles: ERROR from the following cycle, sticky until reset.
    for (int i = 0; i < MW + 1; i++) step(frzv, "wait5");
    apply(idle, "err");
    chk("err state", 32'(State), 32'd3);
    chk("err timeout", 32'(Timeout), 32'd1);
    chk("err stalls", 32'(outs()), 32'b1111000);
    tick();
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "err br");
    tick();
    do_reset();
    apply(idle, "post err");
    chk("post err", 32'({Timeout, State}), 32'd0);
    tick();

    // Branch held through a 3-cycle freeze is flushed on the first free cycle.
    for (int i = 0; i < 3; i++) begin
      apply(brfz, "brfz");
      chk("brfz no flush", 32'({Flush_IF, Flush_ID}), 32'd0);
      tick();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0), "brfz rel");
    chk("brfz release flush", 32'({Flush_IF, Flush_ID, Stall_IF}), 32'b110);
    tick();

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    step(tbl[1].v, "perf lu");
    step(idle, "perf idle");
    step(tbl[5].v, "perf lu");
    step(idle, "perf idle");
    for (int i = 0; i < 3; i++) step(frzv, "perf frz");
    step(idle, "perf idle");
    apply(idle, "perf end");
    chk("perf StallCnt", StallCnt, 32'd5);
    chk("perf FlushCnt", FlushCnt, 32'd0);
    tick();
`endif

    // Randomized traffic with small register numbers so hazards are frequent.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      in_t v;
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.u1  = 1'($urandom); v.u2 = 1'($urandom); v.mr = 1'($urandom);
      v.br  = ($urandom_range(0, 5) == 0);
      v.ma  = ($urandom_range(0, 9) < 7);
      v.wr  = ($urandom_range(0, 9) < 7);
      if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) do_reset();
      else step(v, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
